// File: rtl/ps2_tx_if.sv
// rtl/ps2_tx_if.sv - host/pin bundle for the PS/2 host-to-device transmitter
//
// Signals:
//   ce     tick strobe, one clock wide
//   ps2    pin levels, [0] = PS/2 clock, [1] = PS/2 data (asynchronous)
//   ps2Oe  open-drain enables, 1 pulls the line low (same mapping as ps2)
//   d      command byte, captured when a transfer is accepted
//   valid  start request
//   busy   transfer in progress
//   done   one-clock pulse on device ACK
//   err    one-clock pulse on timeout or NACK
// Modports: master = requester/pin side, slave = ps2_tx.
interface ps2_tx_if;
  logic       ce;
  logic [1:0] ps2;
  logic [1:0] ps2Oe;
  logic [7:0] d;
  logic       valid;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output ce, ps2, d, valid,
    input  ps2Oe, busy, done, err
  );

  modport slave (
    input  ce, ps2, d, valid,
    output ps2Oe, busy, done, err
  );
endinterface

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - PS/2 host-to-device command transmitter (open-drain)
//
// Sends one byte to the keyboard using the host-request protocol: inhibit the
// clock, pull data low, release the clock, then shift start/data/parity/stop
// on device clock falls and sample the device ACK on fall 11.
//
// Parameters:
//   INHIBIT  ce ticks the clock line is held low before the start bit
//   TIMEOUT  ce ticks without a device clock fall before the transfer aborts
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous, active-high
//   bus      ps2_tx_if.slave (ce, ps2, ps2Oe, d, valid, busy, done, err)
// Build option:
//   PS2_TX_FILTER_EN  adds a 4-tick agreement filter on the synchronised clock
module ps2_tx #(
  parameter int INHIBIT = 1000,
  parameter int TIMEOUT = 176000
) (
  input  logic    clock,
  input  logic    reset,
  ps2_tx_if.slave bus
);

  localparam int MAXC = (INHIBIT > TIMEOUT) ? INHIBIT : TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] INH_C   = CW'(INHIBIT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_REQ,
    S_DATA,
    S_STOP,
    S_ACK,
    S_WAIT
  } state_t;

  state_t        state_q, state_n;
  logic [1:0]    sync1_q, sync2_q;
  logic          clk_f, clk_prev_q, fall, data_s;
  logic [1:0]    oe_q, oe_n;
  logic [CW-1:0] tick_q, tick_n;
  logic [3:0]    bit_q, bit_n;
  logic [7:0]    byte_q, byte_n;
  logic          par_q, par_n;
  logic          done_q, done_n;
  logic          err_q, err_n;

  // Pins idle high, so the synchroniser resets to 1s to avoid a false fall.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      clk_prev_q <= 1'b1;
    end else if (bus.ce) begin
      sync1_q    <= bus.ps2;
      sync2_q    <= sync1_q;
      clk_prev_q <= clk_f;
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic       filt_q;
  logic [1:0] agree_q;

  // Level flips only after 4 consecutive samples disagree with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_q  <= 1'b1;
      agree_q <= 2'd0;
    end else if (bus.ce) begin
      if (sync2_q[0] == filt_q) begin
        agree_q <= 2'd0;
      end else if (agree_q == 2'd3) begin
        filt_q  <= sync2_q[0];
        agree_q <= 2'd0;
      end else begin
        agree_q <= agree_q + 2'd1;
      end
    end
  end

  assign clk_f = filt_q;
`else
  assign clk_f = sync2_q[0];
`endif

  assign data_s = sync2_q[1];
  assign fall   = bus.ce & clk_prev_q & ~clk_f;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      oe_q    <= 2'b00;
      tick_q  <= '0;
      bit_q   <= 4'd0;
      byte_q  <= 8'h00;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      oe_q    <= oe_n;
      tick_q  <= tick_n;
      bit_q   <= bit_n;
      byte_q  <= byte_n;
      par_q   <= par_n;
      done_q  <= done_n;
      err_q   <= err_n;
    end
  end

  always_comb begin
    state_n = state_q;
    oe_n    = oe_q;
    tick_n  = tick_q;
    bit_n   = bit_q;
    byte_n  = byte_q;
    par_n   = par_q;
    done_n  = 1'b0;
    err_n   = 1'b0;

    case (state_q)
      S_IDLE: begin
        oe_n = 2'b00;
        // A request in the same cycle as the done/err pulse is dropped.
        if (bus.valid && !done_q && !err_q) begin
          byte_n  = bus.d;
          par_n   = ~^bus.d;
          tick_n  = '0;
          bit_n   = 4'd0;
          state_n = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (bus.ce) begin
          if (tick_q == INH_C) begin
            oe_n    = 2'b11;
            state_n = S_START;
          end else begin
            oe_n   = 2'b01;
            tick_n = tick_q + 1'b1;
          end
        end
      end

      S_START: begin
        if (bus.ce) begin
          oe_n    = 2'b10;
          tick_n  = '0;
          state_n = S_REQ;
        end
      end

      default: begin
        if (bus.ce) begin
          if (fall && state_q != S_WAIT) begin
            tick_n = '0;
            bit_n  = bit_q + 4'd1;
            case (state_q)
              S_REQ: begin
                oe_n    = {~byte_q[0], 1'b0};
                state_n = S_DATA;
              end
              S_DATA: begin
                if (bit_q == 4'd8) begin
                  oe_n    = {~par_q, 1'b0};
                  state_n = S_STOP;
                end else begin
                  oe_n = {~byte_q[bit_q[2:0]], 1'b0};
                end
              end
              S_STOP: begin
                oe_n    = 2'b00;
                state_n = S_ACK;
              end
              default: begin
                // Fall 11: device pulls data low to ACK.
                oe_n = 2'b00;
                if (data_s) begin
                  err_n   = 1'b1;
                  state_n = S_IDLE;
                end else begin
                  state_n = S_WAIT;
                end
              end
            endcase
          end else if (state_q == S_WAIT && clk_f && data_s) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end else if (tick_q == TO_LAST) begin
            err_n   = 1'b1;
            oe_n    = 2'b00;
            state_n = S_IDLE;
          end else begin
            tick_n = fall ? '0 : tick_q + 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.ps2Oe = oe_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - directed self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;
  localparam int INH  = 20;
  localparam int TO   = 400;
  localparam int HALF = 40;

  logic clock = 1'b0;
  logic reset;
  logic dev_clk;
  logic dev_data;
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   done_cnt = 0;
  int   err_cnt  = 0;
  int   inh_cyc  = 0;

  ps2_tx_if bus();

  // Open-drain wired-AND of host enables and device drive.
  assign bus.ps2 = {dev_data & ~bus.ps2Oe[1], dev_clk & ~bus.ps2Oe[0]};

  ps2_tx #(.INHIBIT(INH), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    bus.ce = 1'b0;
    forever begin
      @(posedge clock);
      #1 bus.ce = ~bus.ce;
    end
  end

  always @(negedge clock) begin
    done_cnt = done_cnt + (bus.done ? 1 : 0);
    err_cnt  = err_cnt + (bus.err ? 1 : 0);
    inh_cyc  = inh_cyc + ((bus.ps2Oe == 2'b01) ? 1 : 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic start(input logic [7:0] b);
    @(negedge clock);
    bus.d     = b;
    bus.valid = 1'b1;
    @(negedge clock);
    bus.valid = 1'b0;
    check("busy_rise", 32'(bus.busy), 1);
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (bus.ps2Oe !== 2'b10 && n < 200) begin
      @(negedge clock);
      n++;
    end
    ok = (n < 200);
  endtask

  // Device model: clocks nfalls falls, samples data late in each low phase.
  task automatic device(input int nfalls, input bit ack_low, input int inj_at,
                        output logic [7:0] rx, output logic rx_par, output logic rx_stop);
    bit ok;
    rx = 8'h00; rx_par = 1'b0; rx_stop = 1'b0;
    wait_req(ok);
    check("req_reached", 32'(ok), 1);
    repeat (HALF) @(negedge clock);
    check("start_bit_low", 32'(bus.ps2[1]), 0);
    for (int k = 1; k <= nfalls; k++) begin
      dev_clk = 1'b0;
      for (int c = 0; c < HALF; c++) begin
        @(negedge clock);
        if (k == inj_at) begin
          bus.d     = 8'h55;
          bus.valid = (c == 4);
        end
      end
      if (k <= 8) rx[3'(k-1)] = bus.ps2[1];
      else if (k == 9) rx_par = bus.ps2[1];
      else if (k == 10) rx_stop = bus.ps2[1];
      dev_clk = 1'b1;
      if (k == 10) dev_data = ~ack_low;
      if (k == 11) dev_data = 1'b1;
      else repeat (HALF) @(negedge clock);
    end
  endtask

  task automatic xfer(input string tag, input logic [7:0] b, input logic exp_par,
                      input bit ack_low, input int inj_at, input bit b2b);
    logic [7:0] rx;
    logic rp, rs;
    int d0, e0, i0, n;
    d0 = done_cnt; e0 = err_cnt; i0 = inh_cyc;
    start(b);
    device(11, ack_low, inj_at, rx, rp, rs);
    n = 0;
    while (bus.busy && n < 300) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_end_in_time"}, 32'(n < 300), 1);
    if (ack_low) check({tag, "_done_as_busy_falls"}, 32'(bus.done), 1);
    check({tag, "_inhibit_cycles"}, 32'(inh_cyc - i0), 32'(2 * INH));
    if (b2b) begin
      bus.d     = 8'h3C;
      bus.valid = 1'b1;
      @(negedge clock);
      check({tag, "_valid_with_done_ignored"}, 32'(bus.busy), 0);
      @(negedge clock);
      check({tag, "_valid_next_cycle_taken"}, 32'(bus.busy), 1);
      bus.valid = 1'b0;
    end
    repeat (3) @(negedge clock);
    check({tag, "_byte"}, 32'(rx), 32'(b));
    check({tag, "_parity"}, 32'(rp), 32'(exp_par));
    check({tag, "_stop"}, 32'(rs), 1);
    check({tag, "_done_count"}, 32'(done_cnt - d0), ack_low ? 1 : 0);
    check({tag, "_err_count"}, 32'(err_cnt - e0), ack_low ? 0 : 1);
    if (!b2b) check({tag, "_lines_released"}, 32'(bus.ps2Oe), 0);
  endtask

  initial begin
    logic [7:0] rx;
    logic rp, rs;
    bit ok;
    int d0, e0, t;

    reset = 1'b1; bus.valid = 1'b0; bus.d = 8'h00;
    dev_clk = 1'b1; dev_data = 1'b1;
    repeat (4) @(negedge clock);
    check("rst_oe", 32'(bus.ps2Oe), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_err", 32'(bus.err), 0);
    bus.valid = 1'b1; bus.d = 8'hED;
    @(negedge clock);
    check("reset_beats_valid", 32'(bus.busy), 0);
    bus.valid = 1'b0;
    reset = 1'b0;
    repeat (4) @(negedge clock);

    xfer("ed", 8'hED, 1'b1, 1'b1, 0, 1'b0);
    xfer("ed_inj55", 8'hED, 1'b1, 1'b1, 3, 1'b0);
    xfer("x07", 8'h07, 1'b0, 1'b1, 0, 1'b0);
    xfer("x00", 8'h00, 1'b1, 1'b1, 0, 1'b1);
    pulse_reset();
    check("b2b_reset_oe", 32'(bus.ps2Oe), 0);

    // No device clock at all: abort after TIMEOUT ticks in REQ.
    d0 = done_cnt; e0 = err_cnt;
    start(8'h12);
    wait_req(ok);
    check("to_req_reached", 32'(ok), 1);
    t = 0;
    while (err_cnt == e0 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    check("to_fired", 32'(t < 2000), 1);
    check("to_window", 32'(t >= 2 * TO - 6 && t <= 2 * TO + 6), 1);
    check("to_oe", 32'(bus.ps2Oe), 0);
    check("to_busy", 32'(bus.busy), 0);
    check("to_no_done", 32'(done_cnt - d0), 0);
    repeat (4) @(negedge clock);

    xfer("nack", 8'h5A, 1'b1, 1'b0, 0, 1'b0);

    // Reset in the middle of DATA, after fall 4.
    d0 = done_cnt; e0 = err_cnt;
    start(8'hA5);
    device(4, 1'b1, 0, rx, rp, rs);
    check("mid_bits", 32'(rx[3:0]), 32'h5);
    check("mid_data_driven", 32'(bus.ps2Oe), 32'h2);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_oe", 32'(bus.ps2Oe), 0);
    check("mid_rst_busy", 32'(bus.busy), 0);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    check("mid_rst_no_done", 32'(done_cnt - d0), 0);
    check("mid_rst_no_err", 32'(err_cnt - e0), 0);
    xfer("xff", 8'hFF, 1'b1, 1'b1, 0, 1'b0);

`ifdef PS2_TX_FILTER_EN
    start(8'h81);
    wait_req(ok);
    check("glitch_req_reached", 32'(ok), 1);
    repeat (HALF) @(negedge clock);
    dev_clk = 1'b0;
    repeat (4) @(negedge clock);
    dev_clk = 1'b1;
    repeat (30) @(negedge clock);
    check("glitch_no_fall", 32'(bus.ps2Oe), 32'h2);
    pulse_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
